// File: rtl/sdf_bf_stage16_pkg.sv
// Shared widths, controller state encoding and the sum saturation helper for the
// 16-point SDF butterfly stage. SDF_BF_SAT_EN selects clamping instead of wrap.
package sdf_bf_stage16_pkg;

  localparam int BF_DW    = 16;
  localparam int BF_TW    = 8;
  localparam int BF_FRAC  = 6;
  localparam int BF_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FIRST   = 2'b01,
    ST_SECOND  = 2'b10,
    ST_WAITING = 2'b11
  } bf_state_e;

  // A DW+1 wide sum overflows exactly when its two top bits disagree.
  function automatic logic signed [BF_DW-1:0] fit_sum(input logic signed [BF_DW:0] x);
`ifdef SDF_BF_SAT_EN
    if (!x[BF_DW] && x[BF_DW-1]) begin
      return {1'b0, {(BF_DW-1){1'b1}}};
    end else if (x[BF_DW] && !x[BF_DW-1]) begin
      return {1'b1, {(BF_DW-1){1'b0}}};
    end else begin
      return x[BF_DW-1:0];
    end
`else
    return BF_DW'(x);
`endif
  endfunction

endpackage

// File: rtl/sdf_bf_stage16_if.sv
// Controller-to-butterfly bus: state, aligned port-A data and twiddle in, stage result out.
// valid_o qualifies data_out_r/i on the cycle it is high; there is no back-pressure.
interface sdf_bf_stage16_if;
  import sdf_bf_stage16_pkg::*;

  logic                valid_i;
  logic [1:0]          state;
  logic [BF_DW-1:0]    data_in_r;
  logic [BF_DW-1:0]    data_in_i;
  logic [BF_TW-1:0]    WN_r;
  logic [BF_TW-1:0]    WN_i;
  logic                valid_o;
  logic [BF_DW-1:0]    data_out_r;
  logic [BF_DW-1:0]    data_out_i;

  modport master (
    output valid_i, state, data_in_r, data_in_i, WN_r, WN_i,
    input  valid_o, data_out_r, data_out_i
  );

  modport slave (
    input  valid_i, state, data_in_r, data_in_i, WN_r, WN_i,
    output valid_o, data_out_r, data_out_i
  );

endinterface

// File: rtl/sdf_bf_stage16_cmul.sv
// Combinational complex multiply B*W with round-half-up and FRAC shift.
// SDF_BF_SAT_EN clamps the result to DW bits; otherwise the low DW bits are kept.
module sdf_bf_stage16_cmul #(
  parameter int DW   = 16,
  parameter int TW   = 8,
  parameter int FRAC = 6
) (
  input  logic signed [DW-1:0] b_r_i,
  input  logic signed [DW-1:0] b_i_i,
  input  logic signed [TW-1:0] w_r_i,
  input  logic signed [TW-1:0] w_i_i,
  output logic signed [DW-1:0] p_r_o,
  output logic signed [DW-1:0] p_i_o
);

  localparam int PW = DW + TW;
  localparam int SW = DW + TW + 1;
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC - 1));

  logic signed [PW-1:0] prod_rr;
  logic signed [PW-1:0] prod_ii;
  logic signed [PW-1:0] prod_ri;
  logic signed [PW-1:0] prod_ir;
  logic signed [SW-1:0] re_rnd;
  logic signed [SW-1:0] im_rnd;

  assign prod_rr = PW'(b_r_i) * PW'(w_r_i);
  assign prod_ii = PW'(b_i_i) * PW'(w_i_i);
  assign prod_ri = PW'(b_r_i) * PW'(w_i_i);
  assign prod_ir = PW'(b_i_i) * PW'(w_r_i);

  // Rounding offset is folded in before the shift so the shift floors to nearest.
  assign re_rnd = SW'(prod_rr) - SW'(prod_ii) + HALF;
  assign im_rnd = SW'(prod_ri) + SW'(prod_ir) + HALF;

  function automatic logic signed [DW-1:0] fit_prod(input logic signed [SW-1:0] x);
`ifdef SDF_BF_SAT_EN
    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] p_max;
    logic signed [SW-1:0] p_min;
    shifted = x >>> FRAC;
    p_max   = SW'(2 ** (DW - 1) - 1);
    p_min   = ~p_max;
    if (shifted > p_max) begin
      return p_max[DW-1:0];
    end else if (shifted < p_min) begin
      return p_min[DW-1:0];
    end else begin
      return shifted[DW-1:0];
    end
`else
    return DW'(x >>> FRAC);
`endif
  endfunction

  assign p_r_o = fit_prod(re_rnd);
  assign p_i_o = fit_prod(im_rnd);

endmodule

// File: rtl/sdf_bf_stage16.sv
// Radix-2 DIF single-path delay-feedback butterfly for the 16-point stage.
// SDF_BF_SAT_EN selects saturating arithmetic; undefined gives two's-complement wrap.
module sdf_bf_stage16
  import sdf_bf_stage16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sdf_bf_stage16_if.slave   bf_if
);

  bf_state_e st;

  logic signed [BF_DW-1:0] a_r;
  logic signed [BF_DW-1:0] a_i;
  logic signed [BF_DW-1:0] b_r;
  logic signed [BF_DW-1:0] b_i;
  logic signed [BF_TW-1:0] w_r;
  logic signed [BF_TW-1:0] w_i;

  logic signed [BF_DW:0]   sum_r;
  logic signed [BF_DW:0]   sum_i;
  logic signed [BF_DW:0]   dif_r;
  logic signed [BF_DW:0]   dif_i;
  logic signed [BF_DW-1:0] mul_r;
  logic signed [BF_DW-1:0] mul_i;

  logic signed [BF_DW-1:0] line_r_q [BF_DEPTH];
  logic signed [BF_DW-1:0] line_i_q [BF_DEPTH];
  logic signed [BF_DW-1:0] line_r_d [BF_DEPTH];
  logic signed [BF_DW-1:0] line_i_d [BF_DEPTH];

  logic signed [BF_DW-1:0] push_r;
  logic signed [BF_DW-1:0] push_i;
  logic                    shift_en;

  logic signed [BF_DW-1:0] out_r_q;
  logic signed [BF_DW-1:0] out_i_q;
  logic signed [BF_DW-1:0] out_r_d;
  logic signed [BF_DW-1:0] out_i_d;
  logic                    valid_q;
  logic                    valid_d;

  assign st  = bf_state_e'(bf_if.state);
  assign a_r = bf_if.data_in_r;
  assign a_i = bf_if.data_in_i;
  assign w_r = bf_if.WN_r;
  assign w_i = bf_if.WN_i;

  // Head of the line is the oldest sample: the B input of the butterfly.
  assign b_r = line_r_q[0];
  assign b_i = line_i_q[0];

  assign sum_r = {a_r[BF_DW-1], a_r} + {b_r[BF_DW-1], b_r};
  assign sum_i = {a_i[BF_DW-1], a_i} + {b_i[BF_DW-1], b_i};
  assign dif_r = {b_r[BF_DW-1], b_r} - {a_r[BF_DW-1], a_r};
  assign dif_i = {b_i[BF_DW-1], b_i} - {a_i[BF_DW-1], a_i};

  sdf_bf_stage16_cmul #(
    .DW   (BF_DW),
    .TW   (BF_TW),
    .FRAC (BF_FRAC)
  ) u_cmul (
    .b_r_i (b_r),
    .b_i_i (b_i),
    .w_r_i (w_r),
    .w_i_i (w_i),
    .p_r_o (mul_r),
    .p_i_o (mul_i)
  );

  always_comb begin
    push_r   = a_r;
    push_i   = a_i;
    out_r_d  = '0;
    out_i_d  = '0;
    shift_en = (st != ST_IDLE);
    valid_d  = bf_if.valid_i && ((st == ST_FIRST) || (st == ST_SECOND));
    case (st)
      ST_FIRST: begin
        out_r_d = fit_sum(sum_r);
        out_i_d = fit_sum(sum_i);
        push_r  = fit_sum(dif_r);
        push_i  = fit_sum(dif_i);
      end
      ST_SECOND: begin
        out_r_d = mul_r;
        out_i_d = mul_i;
      end
      default: ;
    endcase
  end

  // The line advances in every non-IDLE state, so back-to-back frames stay aligned.
  always_comb begin
    line_r_d = line_r_q;
    line_i_d = line_i_q;
    if (shift_en) begin
      for (int k = 0; k < BF_DEPTH - 1; k++) begin
        line_r_d[k] = line_r_q[k+1];
        line_i_d[k] = line_i_q[k+1];
      end
      line_r_d[BF_DEPTH-1] = push_r;
      line_i_d[BF_DEPTH-1] = push_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < BF_DEPTH; k++) begin
        line_r_q[k] <= '0;
        line_i_q[k] <= '0;
      end
      out_r_q <= '0;
      out_i_q <= '0;
      valid_q <= 1'b0;
    end else begin
      line_r_q <= line_r_d;
      line_i_q <= line_i_d;
      out_r_q  <= out_r_d;
      out_i_q  <= out_i_d;
      valid_q  <= valid_d;
    end
  end

  assign bf_if.valid_o    = valid_q;
  assign bf_if.data_out_r = out_r_q;
  assign bf_if.data_out_i = out_i_q;

endmodule

// File: tb/tb_sdf_bf_stage16.sv
// Bench for sdf_bf_stage16: FIFO-level reference model, per-cycle compare and literal pins.
// Honours SDF_BF_SAT_EN the same way as the design build.
module tb_sdf_bf_stage16;
  import sdf_bf_stage16_pkg::*;

  localparam int W = 2 * BF_DW + 1;

  logic clk;
  logic rst;

  sdf_bf_stage16_if bf_if ();

  sdf_bf_stage16 dut (
    .clk   (clk),
    .rst   (rst),
    .bf_if (bf_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] trace_q[$];
  int           mdl_r[$];
  int           mdl_i[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] cmp_got;
  logic [W-1:0] cmp_exp;

  function automatic int fit(input longint x);
    longint lim;
    longint m;
    lim = longint'(1) << (BF_DW - 1);
`ifdef SDF_BF_SAT_EN
    if (x > lim - 1) return int'(lim - 1);
    if (x < -lim) return int'(-lim);
    return int'(x);
`else
    m = x & ((lim << 1) - 1);
    if (m >= lim) m = m - (lim << 1);
    return int'(m);
`endif
  endfunction

  function automatic logic [W-1:0] pack(input bit v, input int r, input int i);
    logic [BF_DW-1:0] rr;
    logic [BF_DW-1:0] ii;
    rr = r[BF_DW-1:0];
    ii = i[BF_DW-1:0];
    return {v, rr, ii};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got v=%0b r=%0d i=%0d, expected v=%0b r=%0d i=%0d",
               name, $time, got[W-1], $signed(got[2*BF_DW-1:BF_DW]), $signed(got[BF_DW-1:0]),
               exp[W-1], $signed(exp[2*BF_DW-1:BF_DW]), $signed(exp[BF_DW-1:0]));
    end
  endtask

  task automatic check_lit(input string name, input int idx, input bit v, input int r, input int i);
    if (idx >= trace_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: trace index %0d missing, trace size %0d", name, idx, trace_q.size());
    end else begin
      check(name, trace_q[idx], pack(v, r, i));
    end
  endtask

  task automatic model_clear();
    mdl_r.delete();
    mdl_i.delete();
    for (int k = 0; k < BF_DEPTH; k++) begin
      mdl_r.push_back(0);
      mdl_i.push_back(0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bf_state_e st, input int ar, input int ai,
                      input int wr, input int wi, input bit vi);
    int     br, bi, er, ei, pr, pi;
    longint re, im;
    bit     v;
    @(negedge clk);
    bf_if.state     = st;
    bf_if.valid_i   = vi;
    bf_if.data_in_r = ar[BF_DW-1:0];
    bf_if.data_in_i = ai[BF_DW-1:0];
    bf_if.WN_r      = wr[BF_TW-1:0];
    bf_if.WN_i      = wi[BF_TW-1:0];
    br = mdl_r[0];
    bi = mdl_i[0];
    er = 0;
    ei = 0;
    pr = ar;
    pi = ai;
    if (st == ST_FIRST) begin
      er = fit(longint'(ar) + br);
      ei = fit(longint'(ai) + bi);
      pr = fit(longint'(br) - ar);
      pi = fit(longint'(bi) - ai);
    end else if (st == ST_SECOND) begin
      re = longint'(br) * wr - longint'(bi) * wi;
      im = longint'(br) * wi + longint'(bi) * wr;
      er = fit((re + (longint'(1) << (BF_FRAC - 1))) >>> BF_FRAC);
      ei = fit((im + (longint'(1) << (BF_FRAC - 1))) >>> BF_FRAC);
    end
    if (st != ST_IDLE) begin
      void'(mdl_r.pop_front());
      void'(mdl_i.pop_front());
      mdl_r.push_back(pr);
      mdl_i.push_back(pi);
    end
    v = vi && ((st == ST_FIRST) || (st == ST_SECOND));
    exp_q.push_back(pack(v, er, ei));
    trace_q.push_back(pack(v, er, ei));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    bf_if.state   = ST_IDLE;
    bf_if.valid_i = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int rnd_d();
    return int'($urandom_range(32766)) - 16383;
  endfunction

  function automatic int rnd_w();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic run_frame(input int xr[16], input int xi[16], input int wr[8], input int wi[8],
                           input bit v_first, input bit v_second);
    for (int k = 0; k < 8; k++) step(ST_WAITING, xr[k], xi[k], 0, 0, 1'b0);
    for (int k = 0; k < 8; k++) step(ST_FIRST, xr[8+k], xi[8+k], 64, 0, v_first);
    for (int k = 0; k < 8; k++) step(ST_SECOND, rnd_d(), rnd_d(), wr[k], wi[k], v_second);
  endtask

  // ---------------- compare process ----------------
  always begin
    @(posedge clk);
    #2;
    if (rst && exp_q.size() > 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_got = {bf_if.valid_o, bf_if.data_out_r, bf_if.data_out_i};
      check("cycle_out", cmp_got, cmp_exp);
    end
  end

  // ---------------- stimulus ----------------
  int ramp_r[16], zero_i[16], rand_r[16], rand_i[16];
  int w64_r[8], w0_i[8], tw_r[8], tw_i[8], wr_r[8], wr_i[8];
  int exp2_r[8], exp2_i[8];
  int big_r[16];

  initial begin
    rst = 1'b1;
    bf_if.state     = ST_IDLE;
    bf_if.valid_i   = 1'b0;
    bf_if.data_in_r = '0;
    bf_if.data_in_i = '0;
    bf_if.WN_r      = '0;
    bf_if.WN_i      = '0;
    model_clear();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 check("reset_out", {bf_if.valid_o, bf_if.data_out_r, bf_if.data_out_i}, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) begin
      ramp_r[k] = k + 1;
      zero_i[k] = 0;
      big_r[k]  = 32767;
    end
    for (int k = 0; k < 8; k++) begin
      w64_r[k] = 64;
      w0_i[k]  = 0;
    end
    tw_r = '{64, 45, 0, -46, -64, -46, 0, 45};
    tw_i = '{0, -46, -64, -46, 0, 45, 64, 45};
    exp2_r = '{-8, -6, 0, 6, 8, 6, 0, -6};
    exp2_i = '{0, 6, 8, 6, 0, -6, -8, -6};

    // Ramp, unit twiddle
    trace_q.delete();
    run_frame(ramp_r, zero_i, w64_r, w0_i, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) check_lit("t1_wait", k, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) check_lit("t1_g", 8 + k, 1'b1, 10 + 2 * k, 0);
    for (int k = 0; k < 8; k++) check_lit("t1_h", 16 + k, 1'b1, -8, 0);

    // Ramp, rotating twiddles
    trace_q.delete();
    run_frame(ramp_r, zero_i, tw_r, tw_i, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) check_lit("t2_hw", 16 + k, 1'b1, exp2_r[k], exp2_i[k]);

    // Sum overflow at full scale
    trace_q.delete();
    run_frame(big_r, zero_i, w64_r, w0_i, 1'b1, 1'b1);
`ifdef SDF_BF_SAT_EN
    check_lit("t3_sum_ovf", 8, 1'b1, 32767, 0);
`else
    check_lit("t3_sum_ovf", 8, 1'b1, -2, 0);
`endif
    step(ST_IDLE, 0, 0, 0, 0, 1'b0);

    // Reset during the 4th FIRST cycle
    for (int k = 0; k < 8; k++) step(ST_WAITING, ramp_r[k], 0, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) step(ST_FIRST, ramp_r[8+k], 0, 64, 0, 1'b1);
    @(negedge clk);
    bf_if.state     = ST_FIRST;
    bf_if.data_in_r = BF_DW'(12);
    #1 rst = 1'b0;
    #1 check("t4_async_rst", {bf_if.valid_o, bf_if.data_out_r, bf_if.data_out_i}, '0);
    do_reset(2);
    trace_q.delete();
    for (int k = 0; k < 8; k++) step(ST_FIRST, 100 + k, -k, 64, 0, 1'b1);
    for (int k = 0; k < 8; k++) step(ST_SECOND, 0, 0, 64, 0, 1'b1);
    for (int k = 0; k < 8; k++) check_lit("t4_line_zero", k, 1'b1, 100 + k, -k);
    step(ST_IDLE, 0, 0, 0, 0, 1'b0);

    // Back-to-back frames, no IDLE between them
    for (int k = 0; k < 16; k++) begin
      rand_r[k] = rnd_d();
      rand_i[k] = rnd_d();
    end
    for (int k = 0; k < 8; k++) begin
      wr_r[k] = rnd_w();
      wr_i[k] = rnd_w();
    end
    trace_q.delete();
    run_frame(rand_r, rand_i, wr_r, wr_i, 1'b1, 1'b1);
    run_frame(ramp_r, zero_i, w64_r, w0_i, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) check_lit("t5_wait_inv", 24 + k, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) check_lit("t5_g2", 32 + k, 1'b1, 10 + 2 * k, 0);
    for (int k = 0; k < 8; k++) check_lit("t5_h2", 40 + k, 1'b1, -8, 0);

    // valid_i low through FIRST
    trace_q.delete();
    run_frame(ramp_r, zero_i, w64_r, w0_i, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) check_lit("t6_g_masked", 8 + k, 1'b0, 10 + 2 * k, 0);
    for (int k = 0; k < 8; k++) check_lit("t6_h", 16 + k, 1'b1, -8, 0);

    // Random framed traffic with random gaps and valid
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 16; k++) begin
        rand_r[k] = rnd_d();
        rand_i[k] = rnd_d();
      end
      for (int k = 0; k < 8; k++) begin
        wr_r[k] = rnd_w();
        wr_i[k] = rnd_w();
      end
      run_frame(rand_r, rand_i, wr_r, wr_i, 1'($urandom_range(1)), 1'($urandom_range(1)));
      for (int g = int'($urandom_range(2)); g > 0; g--) step(ST_IDLE, rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'b1);
    end

    // Fully random state sequence
    for (int k = 0; k < 400; k++) begin
      step(bf_state_e'($urandom_range(3)), rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'($urandom_range(1)));
    end
    step(ST_IDLE, 0, 0, 0, 0, 1'b0);

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
